m_data_mem: RTL and testbench



---
 rtl/m_data_mem.sv | 143 ++++++++++++++
 tb/tb_m_data_mem.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/m_data_mem.sv
// m_data_mem: M-stage data memory of the 5-stage MIPS pipeline.
//
// Stores (word/half/byte) commit on the rising clock edge. Loads are
// combinational and sign- or zero-extend half/byte data. A misaligned
// access raises a one-cycle registered err pulse and records its address.
//
// Ports:
//   clk      - pipeline clock, rising edge
//   reset    - asynchronous active-high; clears the array, err and err_addr
//   pc       - PC of the M-stage instruction (trace output only)
//   addr     - byte address from the E/M ALU result
//   wdata    - store data; half/byte data sits in the low bits
//   we       - store enable
//   re       - load enable; qualifies the alignment check only
//   dm_op    - access size: 00 word, 01 half, 10 byte, 11 reserved
//   ld_sign  - 1 sign-extends half/byte loads, 0 zero-extends
//   rdata    - extended load data (combinational)
//   err      - registered misalignment pulse
//   err_addr - address of the last faulting access
//
// Optional feature: define DM_TRACE_EN to print one line per committed store.

module m_data_mem #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  dm_op,
  input  logic        ld_sign,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] OP_WORD = 2'b00;
  localparam logic [1:0] OP_HALF = 2'b01;
  localparam logic [1:0] OP_BYTE = 2'b10;

  logic [31:0]           mem [0:DEPTH-1];
  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic [31:0]           cur;
  logic [31:0]           merged;
  logic                  misal;
  logic                  commit;
  logic                  fault;

  // Merge store data into the current word; unselected lanes are preserved.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] wd,
                                             input logic [1:0]  op,
                                             input logic [1:0]  ln);
    logic [31:0] w;
    w = old_w;
    case (op)
      OP_WORD: w = wd;
      OP_HALF: if (ln[1]) w[31:16] = wd[15:0];
               else       w[15:0]  = wd[15:0];
      OP_BYTE: w[{ln, 3'b000} +: 8] = wd[7:0];
      default: w = old_w;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  assign off  = addr - BASE_ADDR;
  // Offset bits above the array size are dropped so accesses wrap.
  assign idx  = off[DEPTH_LOG2+1:2];
  assign lane = off[1:0];
  assign cur  = mem[idx];

  always_comb begin
    misal = 1'b0;
    case (dm_op)
      OP_WORD: misal = (lane != 2'b00);
      OP_HALF: misal = lane[0];
      OP_BYTE: misal = 1'b0;
      default: misal = 1'b1;
    endcase
  end

  assign fault  = (we | re) & misal;
  assign commit = we & ~misal;
  assign merged = merge_word(cur, wdata, dm_op, lane);

  always_comb begin
    rdata = 32'h0;
    case (dm_op)
      OP_WORD: rdata = cur;
      OP_HALF: rdata = ext16(lane[1] ? cur[31:16] : cur[15:0], ld_sign);
      OP_BYTE: rdata = ext8(cur[{lane, 3'b000} +: 8], ld_sign);
      default: rdata = 32'h0;
    endcase
  end

  // Store commit edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (commit) begin
      mem[idx] <= merged;
`ifdef DM_TRACE_EN
      $display("%d@%h: *%h <= %h", $time, pc,
               BASE_ADDR + 32'({idx, 2'b00}), merged);
`endif
    end
  end

  // Fault capture edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err      <= 1'b0;
      err_addr <= 32'h0;
    end else begin
      err <= fault;
      if (fault) err_addr <= addr;
    end
  end

  logic unused_off;
  assign unused_off = ^off[31:DEPTH_LOG2+2];
`ifndef DM_TRACE_EN
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_m_data_mem.sv
module tb_m_data_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0, addr = '0, wdata = '0;
  logic        we = 1'b0, re = 1'b0, ld_sign = 1'b0;
  logic [1:0]  dm_op = 2'b00;
  logic [31:0] rdata, err_addr;
  logic        err;

  m_data_mem dut (
    .clk(clk), .reset(reset), .pc(pc), .addr(addr), .wdata(wdata),
    .we(we), .re(re), .dm_op(dm_op), .ld_sign(ld_sign),
    .rdata(rdata), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // Reference model: flat little-endian byte array of 16 KiB.
  localparam int NBYTES = 16384;
  byte unsigned mb [NBYTES];
  bit           m_err;
  logic [31:0]  m_err_addr;

  typedef struct {
    logic [31:0] rd;
    logic        e;
    logic [31:0] ea;
    string       tag;
  } exp_t;
  exp_t q[$];

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_misal(input logic [1:0] op, input int unsigned o);
    case (op)
      2'd0: return (o % 4) != 0;
      2'd1: return (o % 2) != 0;
      2'd2: return 0;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] op, input bit sgn);
    int unsigned o, b, wb, hb;
    logic [31:0] v;
    o  = a;               // BASE_ADDR is 0 in this bench
    b  = o % NBYTES;
    wb = b - (b % 4);
    hb = wb + (((b % 4) >= 2) ? 2 : 0);
    case (op)
      2'd0: v = {mb[wb+3], mb[wb+2], mb[wb+1], mb[wb]};
      2'd1: begin
        v = {16'h0, mb[hb+1], mb[hb]};
        if (sgn && v[15]) v = v | 32'hFFFF_0000;
      end
      2'd2: begin
        v = {24'h0, mb[b]};
        if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      end
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
    m_err = 0;
    m_err_addr = 32'h0;
  endtask

  // One pipeline cycle: drive, record expectation, advance the model.
  task automatic cyc(input string tag, input bit w, input bit r, input logic [1:0] op,
                     input bit sgn, input logic [31:0] a, input logic [31:0] d);
    exp_t it;
    int unsigned b, wb, hb;
    bit mis;
    @(posedge clk); #1;
    we = w; re = r; dm_op = op; ld_sign = sgn; addr = a; wdata = d; pc = pc + 4;
    it.rd = model_load(a, op, sgn);
    it.e = m_err; it.ea = m_err_addr; it.tag = tag;
    q.push_back(it);
    mis = is_misal(op, a);
    b  = a % NBYTES;
    wb = b - (b % 4);
    hb = wb + (((b % 4) >= 2) ? 2 : 0);
    if (w && !mis) begin
      case (op)
        2'd0: for (int k = 0; k < 4; k++) mb[wb+k] = d[8*k +: 8];
        2'd1: begin mb[hb] = d[7:0]; mb[hb+1] = d[15:8]; end
        2'd2: mb[b] = d[7:0];
        default: ;
      endcase
    end
    m_err = (w || r) && mis;
    if (m_err) m_err_addr = a;
  endtask

  // Monitor: every mid-cycle the DUT presents rdata/err for one issued cycle.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it = q.pop_front();
        chk({it.tag, ".rdata"}, rdata, it.rd);
        chk({it.tag, ".err"}, {31'h0, err}, {31'h0, it.e});
        chk({it.tag, ".err_addr"}, err_addr, it.ea);
      end
    end
  end

  initial begin
    model_clear();
    #3;
    chk("reset.err", {31'h0, err}, 32'h0);
    chk("reset.err_addr", err_addr, 32'h0);
    chk("reset.rdata", rdata, 32'h0);
    #4 reset = 1'b0;

    cyc("lw0", 0, 1, 2'd0, 0, 32'h0, 0);
    cyc("lw4", 0, 1, 2'd0, 0, 32'h4, 0);
    cyc("lwlast", 0, 1, 2'd0, 0, 32'hFFFC, 0);
    cyc("sw10", 1, 0, 2'd0, 0, 32'h10, 32'h1234_5678);
    cyc("lw10", 0, 1, 2'd0, 0, 32'h10, 0);
    cyc("sb11", 1, 0, 2'd2, 0, 32'h11, 32'h0000_00AB);
    cyc("lw10b", 0, 1, 2'd0, 0, 32'h10, 0);
    cyc("lb11", 0, 1, 2'd2, 1, 32'h11, 0);
    cyc("lbu11", 0, 1, 2'd2, 0, 32'h11, 0);
    cyc("sh12", 1, 0, 2'd1, 0, 32'h12, 32'h0000_8001);
    cyc("lw10c", 0, 1, 2'd0, 0, 32'h10, 0);
    cyc("lh12", 0, 1, 2'd1, 1, 32'h12, 0);
    cyc("lhu12", 0, 1, 2'd1, 0, 32'h12, 0);
    cyc("sw22mis", 1, 0, 2'd0, 0, 32'h22, 32'hCAFE_F00D);
    cyc("lh13mis", 0, 1, 2'd1, 1, 32'h13, 0);
    cyc("lw20", 0, 1, 2'd0, 0, 32'h20, 0);
    cyc("idle", 0, 0, 2'd3, 0, 32'h20, 0);
    cyc("rsvwe", 1, 1, 2'd3, 0, 32'h44, 32'hFFFF_FFFF);
    cyc("sw4000", 1, 0, 2'd0, 0, 32'h4000, 32'hA5A5_0F0F);
    cyc("lw0wrap", 0, 1, 2'd0, 0, 32'h0, 0);
    cyc("sw30old", 1, 0, 2'd0, 0, 32'h30, 32'h1);
    cyc("sw30rdw", 1, 0, 2'd0, 0, 32'h30, 32'hDEAD_BEEF);
    cyc("lw30", 0, 1, 2'd0, 0, 32'h30, 0);
    cyc("errseed", 0, 1, 2'd1, 0, 32'h55, 0);

    // Store in flight, then an asynchronous reset before the edge.
    @(posedge clk); #1;
    we = 1; re = 0; dm_op = 2'd0; addr = 32'h10; wdata = 32'h7777_7777;
    #1 chk("pre_reset.rdata", rdata, 32'h8001_AB78);
    #1 reset = 1'b1; we = 0;
    #1;
    chk("async_reset.rdata", rdata, 32'h0);
    chk("async_reset.err", {31'h0, err}, 32'h0);
    chk("async_reset.err_addr", err_addr, 32'h0);
    reset = 1'b0;
    model_clear();
    cyc("post_reset_lw10", 0, 1, 2'd0, 0, 32'h10, 0);
    cyc("post_reset_lw30", 0, 1, 2'd0, 0, 32'h30, 0);

    // Randomized traffic over a small window with occasional wrap aliases.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) a = a | ($urandom_range(1, 15) << 14);
      cyc("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
    end
    cyc("tail", 0, 0, 2'd0, 0, 32'h0, 0);

    for (int t = 0; t < 5 && q.size() > 0; t++) @(posedge clk);
    if (q.size() != 0) begin
      tot_cnt++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
